// File: rtl/avmm_req_arbiter.sv
// ---------------------------------------------------------------------------
// avmm_req_arbiter
//
// Shares one Avalon-MM configuration master port between NUM_REQ requesters
// (e.g. DV config driver, link-training sequencer, calibration engine) using
// round-robin arbitration with a single transaction in flight. Read data is
// routed back only to the requester that issued the read.
//
// Optional feature macro: AVMM_ARB_TIMEOUT_EN
//   When defined, a read left unanswered for TIMEOUT_CYCLES cycles in RDWAIT
//   is completed locally with all-ones data and timeout_err is set (sticky).
//   When undefined, RDWAIT waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_address         NUM_REQ x 17-bit requester addresses ([i*17 +: 17])
//   s_read/s_write    per-requester read / write strobes
//   s_writedata       NUM_REQ x AVMM_WIDTH write data
//   s_byteenable      NUM_REQ x BYTE_WIDTH byte enables
//   s_waitrequest     per-requester waitrequest (low only for the owner in CMD)
//   s_readdata        shared read data (copy of m_readdata)
//   s_readdatavalid   per-requester read data valid
//   m_*               single Avalon-MM master port towards the CSR target
//   grant             one-hot current owner, 0 when idle
//   timeout_err       sticky read-timeout flag
// ---------------------------------------------------------------------------
module avmm_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AVMM_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ*17-1:0]           s_address,
    input  logic [NUM_REQ-1:0]              s_read,
    input  logic [NUM_REQ-1:0]              s_write,
    input  logic [NUM_REQ*AVMM_WIDTH-1:0]   s_writedata,
    input  logic [NUM_REQ*BYTE_WIDTH-1:0]   s_byteenable,
    output logic [NUM_REQ-1:0]              s_waitrequest,
    output logic [AVMM_WIDTH-1:0]           s_readdata,
    output logic [NUM_REQ-1:0]              s_readdatavalid,
    output logic [16:0]                     m_address,
    output logic                            m_read,
    output logic                            m_write,
    output logic [AVMM_WIDTH-1:0]           m_writedata,
    output logic [BYTE_WIDTH-1:0]           m_byteenable,
    input  logic [AVMM_WIDTH-1:0]           m_readdata,
    input  logic                            m_readdatavalid,
    input  logic                            m_waitrequest,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("avmm_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

    state_t               state_reg, state_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]     gidx_reg, gidx_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;

    logic [NUM_REQ-1:0]   pending;
    logic [16:0]          addr_m  [NUM_REQ];
    logic [AVMM_WIDTH-1:0] wdata_m [NUM_REQ];
    logic [BYTE_WIDTH-1:0] be_m    [NUM_REQ];
    logic [16:0]          g_addr;
    logic [AVMM_WIDTH-1:0] g_wdata;
    logic [BYTE_WIDTH-1:0] g_be;
    logic                 g_rd, g_wr;
    logic                 sel_found;
    logic [PTR_W-1:0]     sel_idx;
    logic                 accept;
    logic                 timeout_hit;

    // Per-requester fields masked by grant; OR-reducing them gives the owner's
    // signals, and all zeros when nobody owns the port.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign pending[gi] = s_read[gi] | s_write[gi];
        assign addr_m[gi]  = grant_reg[gi] ? s_address[gi*17 +: 17] : '0;
        assign wdata_m[gi] = grant_reg[gi] ? s_writedata[gi*AVMM_WIDTH +: AVMM_WIDTH] : '0;
        assign be_m[gi]    = grant_reg[gi] ? s_byteenable[gi*BYTE_WIDTH +: BYTE_WIDTH] : '0;
    end

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            g_addr  = g_addr | addr_m[i];
            g_wdata = g_wdata | wdata_m[i];
            g_be    = g_be | be_m[i];
        end
    end

    assign g_rd = |(grant_reg & s_read);
    assign g_wr = |(grant_reg & s_write);

    assign m_address    = g_addr;
    assign m_writedata  = g_wdata;
    assign m_byteenable = g_be;
    // Simultaneous read+write from the owner is issued as a write only.
    assign m_write      = (state_reg == CMD) & g_wr;
    assign m_read       = (state_reg == CMD) & g_rd & ~g_wr;
    assign accept       = (state_reg == CMD) & ~m_waitrequest & (m_read | m_write);
    assign grant        = grant_reg;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            gidx_reg   <= '0;
            grant_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            gidx_reg   <= gidx_next;
            grant_reg  <= grant_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        gidx_next   = gidx_reg;
        grant_next  = grant_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    grant_next = NUM_REQ'(1) << sel_idx;
                    gidx_next  = sel_idx;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (accept) begin
                    rr_ptr_next = (gidx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;
                    if (m_write) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end else begin
                        state_next = RDWAIT;
                    end
                end else if (!(g_rd | g_wr)) begin
                    // Owner withdrew its request before accept: release the
                    // port without advancing the round-robin pointer.
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            RDWAIT: begin
                if (m_readdatavalid || timeout_hit) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_comb begin
        s_waitrequest = '1;
        if (state_reg == CMD) begin
            s_waitrequest = ~grant_reg | {NUM_REQ{m_waitrequest}};
        end
    end

    assign s_readdatavalid = ((state_reg == RDWAIT) && (m_readdatavalid || timeout_hit))
                             ? grant_reg : '0;
    assign s_readdata      = timeout_hit ? '1 : m_readdata;

`ifdef AVMM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] to_cnt_reg;
    logic             timeout_err_reg;

    // A genuine response in the final cycle takes priority over the timeout.
    assign timeout_hit = (state_reg == RDWAIT) && !m_readdatavalid &&
                         (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside RDWAIT, so it starts from 0 on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg != RDWAIT) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
